// File: rtl/iterative_val2_shifter.sv
// Operand-2 generator: ARM shifter operands, load/store offset and shifter carry-out.
// Latency: 1 + ceil(n/SHIFT_STEP) edges from accept to out_valid (1 when n=0, 2 for RRX).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module iterative_val2_shifter #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             imm,
    input  logic [11:0]      shift_operand,
    input  logic             mem_R_en,
    input  logic             mem_W_en,
    input  logic [WIDTH-1:0] val_rm,
    input  logic [7:0]       val_rs,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val2,
    output logic             c_out
);
    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] K_LSL = 2'd0;
    localparam logic [1:0] K_LSR = 2'd1;
    localparam logic [1:0] K_ASR = 2'd2;
    localparam logic [1:0] K_ROR = 2'd3;

    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);
    localparam logic [31:0]   W32    = 32'(WIDTH);
    localparam logic [31:0]   WP1    = 32'(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] opnd;
    logic [1:0]       kind;
    logic             rrx;
    logic             carry;
    logic [CW-1:0]    rem;

    logic [WIDTH-1:0] d_opnd;
    logic [1:0]       d_kind;
    logic             d_rrx;
    logic             d_carry;
    logic [CW-1:0]    d_n;
    logic [31:0]      n32;
    logic [31:0]      a32;
    logic [31:0]      r32;

    always_comb begin
        d_opnd  = val_rm;
        d_kind  = shift_operand[6:5];
        d_rrx   = 1'b0;
        d_carry = c_in;
        n32     = '0;
        a32     = 32'(shift_operand[11:7]);
        r32     = 32'(val_rs);
        if (mem_R_en || mem_W_en) begin
            d_opnd = WIDTH'(shift_operand);
        end else if (imm) begin
            d_opnd = WIDTH'(shift_operand[7:0]);
            d_kind = K_ROR;
            n32    = 32'({shift_operand[11:8], 1'b0});
        end else if (!shift_operand[4]) begin
            case (d_kind)
                K_LSL:        n32 = a32;
                K_LSR, K_ASR: n32 = (a32 == 32'd0) ? W32 : a32;
                K_ROR: begin
                    if (a32 == 32'd0) begin
                        d_rrx = 1'b1;
                        n32   = 32'd1;
                    end else begin
                        n32 = a32;
                    end
                end
            endcase
        end else if (r32 != 32'd0) begin
            if (d_kind == K_ROR) begin
                n32 = r32 % W32;
                // A full-turn rotate leaves Rm intact but still reports its MSB as carry.
                if (n32 == 32'd0) d_carry = val_rm[WIDTH-1];
            end else begin
                n32 = r32;
            end
        end
        // Anything past WIDTH+1 gives the same result as WIDTH+1 for plain shifts.
        if (d_kind != K_ROR && n32 > WP1) n32 = WP1;
        d_n = CW'(n32);
    end

    logic [CW-1:0]    s;
    logic [31:0]      s32;
    logic [WIDTH-1:0] lsl_t;
    logic [WIDTH-1:0] rsh_t;
    logic [WIDTH-1:0] step_res;
    logic             step_c;

    always_comb begin
        s        = (rem < STEP_C) ? rem : STEP_C;
        s32      = 32'(s);
        lsl_t    = opnd << (s32 - 32'd1);
        rsh_t    = opnd >> (s32 - 32'd1);
        step_res = opnd;
        step_c   = rsh_t[0];
        case (kind)
            K_LSL: begin
                step_res = opnd << s32;
                step_c   = lsl_t[WIDTH-1];
            end
            K_LSR: step_res = opnd >> s32;
            K_ASR: step_res = $signed(opnd) >>> s32;
            K_ROR: step_res = (opnd >> s32) | (opnd << (W32 - s32));
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state <= IDLE;
            opnd  <= '0;
            kind  <= K_LSL;
            rrx   <= 1'b0;
            carry <= 1'b0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opnd  <= d_opnd;
                        kind  <= d_kind;
                        rrx   <= d_rrx;
                        carry <= d_carry;
                        rem   <= d_n;
                        state <= (d_n == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (rrx) begin
                        opnd  <= {carry, opnd[WIDTH-1:1]};
                        carry <= opnd[0];
                        rem   <= '0;
                        state <= DONE;
                    end else begin
                        opnd  <= step_res;
                        carry <= step_c;
                        rem   <= rem - s;
                        if (rem == s) state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign val2      = opnd;
    assign c_out     = carry;
endmodule

// File: tb/tb_iterative_val2_shifter.sv
// Bench for iterative_val2_shifter: directed vectors feed a scoreboard queue,
// an independent monitor compares val2, c_out and latency on each presented result.
module tb_iterative_val2_shifter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, imm, mem_R_en, mem_W_en, c_in, out_ready, sel;
    logic [11:0] shift_operand;
    logic [31:0] val_rm;
    logic [7:0]  val_rs;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, c_out0, c_out1;
    logic [31:0] val2_0, val2_1;
    logic        in_valid0, in_valid1, in_ready_m, out_valid_m, c_out_m;
    logic [31:0] val2_m;

    assign in_valid0   = in_valid & ~sel;
    assign in_valid1   = in_valid & sel;
    assign in_ready_m  = sel ? in_ready1 : in_ready0;
    assign out_valid_m = sel ? out_valid1 : out_valid0;
    assign c_out_m     = sel ? c_out1 : c_out0;
    assign val2_m      = sel ? val2_1 : val2_0;

    iterative_val2_shifter #(.WIDTH(32), .SHIFT_STEP(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
        .imm(imm), .shift_operand(shift_operand), .mem_R_en(mem_R_en), .mem_W_en(mem_W_en),
        .val_rm(val_rm), .val_rs(val_rs), .c_in(c_in), .out_valid(out_valid0),
        .out_ready(out_ready), .val2(val2_0), .c_out(c_out0)
    );

    iterative_val2_shifter #(.WIDTH(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1),
        .imm(imm), .shift_operand(shift_operand), .mem_R_en(mem_R_en), .mem_W_en(mem_W_en),
        .val_rm(val_rm), .val_rs(val_rs), .c_in(c_in), .out_valid(out_valid1),
        .out_ready(out_ready), .val2(val2_1), .c_out(c_out1)
    );

    typedef struct {
        string       name;
        logic [31:0] v;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_note(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Monitor: one comparison set per rising out_valid.
    initial begin
        exp_t e;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid_m && !prev) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got val2=0x%08h c_out=%0b, expected no result",
                             val2_m, c_out_m);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_val2"}, val2_m, e.v);
                    chk({e.name, "_c_out"}, 32'(c_out_m), 32'(e.c));
                    chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            prev = out_valid_m;
        end
    end

    task automatic send(input string name, input bit s, input bit i, input logic [11:0] so,
                        input bit r, input bit w, input logic [31:0] rm, input logic [7:0] rs,
                        input bit ci, input bit push, input logic [31:0] ev, input bit ec,
                        input int el);
        exp_t e;
        int   k = 0;
        @(negedge clk);
        sel = s;
        while (!in_ready_m && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_note({name, "_accept"});
        imm = i; shift_operand = so; mem_R_en = r; mem_W_en = w;
        val_rm = rm; val_rs = rs; c_in = ci;
        if (push) begin
            e.name = name; e.v = ev; e.c = ec; e.lat = el; e.acc = cyc;
            q.push_back(e);
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(in_ready_m && !out_valid_m) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_note({name, "_idle"});
    endtask

    task automatic run(input string name, input bit i, input logic [11:0] so, input bit r,
                       input logic [31:0] rm, input logic [7:0] rs, input bit ci,
                       input logic [31:0] ev, input bit ec, input int el);
        send(name, 1'b0, i, so, r, 1'b0, rm, rs, ci, 1'b1, ev, ec, el);
        wait_idle(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; imm = 1'b0; mem_R_en = 1'b0;
        mem_W_en = 1'b0; c_in = 1'b0; out_ready = 1'b1; sel = 1'b0;
        shift_operand = '0; val_rm = '0; val_rs = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_out_valid", 32'(out_valid0), 32'd0);
        chk("reset_val2", val2_0, 32'd0);
        chk("reset_c_out", 32'(c_out0), 32'd0);
        chk("reset_in_ready", 32'(in_ready0), 32'd1);

        //  name            imm so       ld rm            rs      cin exp_val2      c  lat
        run("imm_rot",      1, 12'h4FF, 0, 32'h0,        8'd0,   0, 32'hFF000000, 1, 2);
        run("imm_rot0",     1, 12'h0AB, 0, 32'h0,        8'd0,   1, 32'h000000AB, 1, 1);
        run("lsl_reg32",    0, 12'h010, 0, 32'hFFFFFFFF, 8'd32,  0, 32'h00000000, 1, 5);
        run("lsl_reg40",    0, 12'h010, 0, 32'hFFFFFFFF, 8'd40,  0, 32'h00000000, 0, 6);
        run("lsl_reg0",     0, 12'h010, 0, 32'hFFFFFFFF, 8'd0,   1, 32'hFFFFFFFF, 1, 1);
        run("asr_imm0",     0, 12'h040, 0, 32'h80000000, 8'd0,   0, 32'hFFFFFFFF, 1, 5);
        run("lsr_imm0",     0, 12'h020, 0, 32'h80000000, 8'd0,   0, 32'h00000000, 1, 5);
        run("rrx",          0, 12'h060, 0, 32'h00000001, 8'd0,   1, 32'h80000000, 1, 2);
        run("ror_reg64",    0, 12'h070, 0, 32'h80000001, 8'd64,  0, 32'h80000001, 1, 1);
        run("lsl_imm4",     0, 12'h200, 0, 32'h1000000F, 8'd0,   0, 32'h000000F0, 1, 2);
        run("asr_imm12",    0, 12'h640, 0, 32'h8000F000, 8'd0,   1, 32'hFFF8000F, 0, 3);
        run("lsr_reg9",     0, 12'h030, 0, 32'h00000300, 8'd9,   0, 32'h00000001, 1, 3);
        run("asr_reg200",   0, 12'h050, 0, 32'h80000000, 8'd200, 0, 32'hFFFFFFFF, 1, 6);

        // Held result under backpressure; a competing request must be ignored.
        out_ready = 1'b0;
        send("ls_offset", 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b0, 32'h12345678, 8'd0, 1'b1,
             1'b1, 32'h00000FFF, 1'b1, 1);
        imm = 1'b1; mem_R_en = 1'b0; shift_operand = 12'h4FF; c_in = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid0), 32'd1);
            chk("hold_val2", val2_0, 32'h00000FFF);
            chk("hold_c_out", 32'(c_out0), 32'd1);
            chk("hold_in_ready", 32'(in_ready0), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        wait_idle("hold");
        repeat (12) @(negedge clk);

        // Abort a 33-bit LSL mid-shift by flush, then by reset.
        send("flush_abort", 1'b0, 1'b0, 12'h010, 1'b0, 1'b0, 32'hFFFFFFFF, 8'd33, 1'b0,
             1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid0), 32'd0);
        chk("flush_val2", val2_0, 32'd0);
        chk("flush_in_ready", 32'(in_ready0), 32'd1);
        repeat (10) @(negedge clk);

        send("rst_abort", 1'b0, 1'b0, 12'h010, 1'b0, 1'b0, 32'hFFFFFFFF, 8'd33, 1'b0,
             1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_val2", val2_0, 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        repeat (10) @(negedge clk);

        // Single-bit-per-cycle instance.
        send("step1_imm_rot", 1'b1, 1'b1, 12'h4FF, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0,
             1'b1, 32'hFF000000, 1'b1, 9);
        wait_idle("step1");
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
